// File: rtl/minisrc_pkg.sv
// MiniSRC shared definitions: opcodes, ALU control codes,
// issue FSM state encoding and the decoder output bundle.
package minisrc_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_ROR  = 4'd4;
    localparam logic [3:0] ALU_ROL  = 4'd5;
    localparam logic [3:0] ALU_SHR  = 4'd6;
    localparam logic [3:0] ALU_SHRA = 4'd7;
    localparam logic [3:0] ALU_SHL  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;
    localparam logic [3:0] ALU_NEG  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       is_imm;
        logic       is_muldiv;
        logic       is_unary;
        logic       legal;
    } dec_t;

    function automatic logic [31:0] sext19(input logic [18:0] imm);
        return {{13{imm[18]}}, imm};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: maps a MiniSRC opcode to the
// ALU control code and operand-selection attributes.
module alu_op_decode
    import minisrc_pkg::*;
(
    input  logic [4:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec       = '0;
        dec.legal = 1'b1;
        unique case (1'b1)
            (opcode == OP_ADD):  dec.ctrl = ALU_ADD;
            (opcode == OP_SUB):  dec.ctrl = ALU_SUB;
            (opcode == OP_AND):  dec.ctrl = ALU_AND;
            (opcode == OP_OR):   dec.ctrl = ALU_OR;
            (opcode == OP_ROR):  dec.ctrl = ALU_ROR;
            (opcode == OP_ROL):  dec.ctrl = ALU_ROL;
            (opcode == OP_SHR):  dec.ctrl = ALU_SHR;
            (opcode == OP_SHRA): dec.ctrl = ALU_SHRA;
            (opcode == OP_SHL):  dec.ctrl = ALU_SHL;
            (opcode == OP_ADDI): begin
                dec.ctrl   = ALU_ADD;
                dec.is_imm = 1'b1;
            end
            (opcode == OP_ANDI): begin
                dec.ctrl   = ALU_AND;
                dec.is_imm = 1'b1;
            end
            (opcode == OP_ORI): begin
                dec.ctrl   = ALU_OR;
                dec.is_imm = 1'b1;
            end
            (opcode == OP_MUL): begin
                dec.ctrl      = ALU_MUL;
                dec.is_muldiv = 1'b1;
            end
            (opcode == OP_DIV): begin
                dec.ctrl      = ALU_DIV;
                dec.is_muldiv = 1'b1;
            end
            (opcode == OP_NEG): begin
                dec.ctrl     = ALU_NEG;
                dec.is_unary = 1'b1;
            end
            (opcode == OP_NOT): begin
                dec.ctrl     = ALU_NOT;
                dec.is_unary = 1'b1;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue side of the ALU: reads operands, drives the ALU, waits
// its settle latency, then writes back to the regfile or HI/LO.
module alu_issue_ctrl
    import minisrc_pkg::*;
#(
    parameter int EXEC_LAT   = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [31:0] rf_rdata_a,
    input  logic [31:0] rf_rdata_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_c0,
    input  logic [31:0] alu_c1,
    input  logic        alu_zero,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        zero_flag,
    output logic        done,
    output logic        illegal,
    output logic        div0
);

    localparam int MAXL = (EXEC_LAT > MULDIV_LAT) ? EXEC_LAT : MULDIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   instr_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   c0_q;
    logic [31:0]   c1_q;
    logic          ill_q;
    logic          div0_q;
    dec_t          dec;

    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;

    assign ra = instr_q[26:23];
    assign rb = instr_q[22:19];
    assign rc = instr_q[18:15];

    alu_op_decode u_dec (
        .opcode (instr_q[31:27]),
        .dec    (dec)
    );

    // mul/div read ra/rb; everything else reads rb/rc
    always_comb begin
        rf_raddr_a = rb;
        rf_raddr_b = rc;
        if (dec.is_muldiv) begin
            rf_raddr_a = ra;
            rf_raddr_b = rb;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (instr_valid) state_d = S_READ;
            S_READ: state_d = dec.legal ? S_EXEC : S_WB;
            S_EXEC: if (cnt_q == '0) state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            instr_q   <= '0;
            cnt_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            c0_q      <= '0;
            c1_q      <= '0;
            zero_flag <= 1'b0;
            ill_q     <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (instr_valid) instr_q <= instr;
                end
                S_READ: begin
                    ill_q  <= ~dec.legal;
                    div0_q <= dec.legal && (dec.ctrl == ALU_DIV)
                              && (rf_rdata_b == '0);
                    if (dec.legal) begin
                        alu_a    <= rf_rdata_a;
                        alu_ctrl <= dec.ctrl;
                        if (dec.is_imm) begin
                            alu_b <= sext19(instr_q[18:0]);
                        end else if (dec.is_unary) begin
                            alu_b <= '0;
                        end else begin
                            alu_b <= rf_rdata_b;
                        end
                        cnt_q <= dec.is_muldiv ? CW'(MULDIV_LAT - 1)
                                               : CW'(EXEC_LAT - 1);
                    end
                end
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        c0_q <= alu_c0;
                        c1_q <= alu_c1;
                        if (!div0_q) zero_flag <= alu_zero;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign done        = (state_q == S_WB);
    assign illegal     = done && ill_q;
    assign div0        = done && div0_q;
    assign rf_we       = done && !ill_q && !dec.is_muldiv;
    assign hilo_we     = done && !ill_q && dec.is_muldiv && !div0_q;
    assign rf_waddr    = ra;
    assign rf_wdata    = c0_q;
    assign hi_wdata    = c1_q;
    assign lo_wdata    = c0_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural regfile
// and ALU; expected completions go through a queue.
module tb_alu_issue_ctrl;
    import minisrc_pkg::*;

    logic        clk = 1'b0;
    logic        nRst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [3:0]  rf_raddr_a, rf_raddr_b;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_c0, alu_c1;
    logic        alu_zero;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hilo_we;
    logic [31:0] hi_wdata, lo_wdata;
    logic        zero_flag, done, illegal, div0;

    logic [31:0] regs [16];
    logic [63:0] alu_res;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          lat;
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic        hwe;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zf;
        logic        ill;
        logic        dz;
        logic [3:0]  ctrl;
        logic [31:0] b;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign rf_rdata_a = regs[rf_raddr_a];
    assign rf_rdata_b = regs[rf_raddr_b];

    function automatic logic [63:0] alu_model(
        input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  s;
        s = b[4:0];
        r = '0;
        case (c)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_ROR:  r = (a >> s) | (a << (6'd32 - {1'b0, s}));
            ALU_ROL:  r = (a << s) | (a >> (6'd32 - {1'b0, s}));
            ALU_SHR:  r = a >> s;
            ALU_SHRA: r = $signed(a) >>> s;
            ALU_SHL:  r = a << s;
            ALU_MUL:  return {32'b0, a} * {32'b0, b};
            ALU_DIV:  return (b == 0) ? {32'h0, 32'hFFFF_FFFF}
                                      : {a % b, a / b};
            ALU_NEG:  r = -a;
            ALU_NOT:  r = ~a;
            default:  r = '0;
        endcase
        return {32'b0, r};
    endfunction

    always_comb alu_res = alu_model(alu_ctrl, alu_a, alu_b);
    assign alu_c0   = alu_res[31:0];
    assign alu_c1   = alu_res[63:32];
    assign alu_zero = (alu_res[31:0] == 32'b0);

    alu_issue_ctrl #(.EXEC_LAT(1), .MULDIV_LAT(4)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_rdata_a  (rf_rdata_a),
        .rf_rdata_b  (rf_rdata_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_c0      (alu_c0),
        .alu_c1      (alu_c1),
        .alu_zero    (alu_zero),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .hilo_we     (hilo_we),
        .hi_wdata    (hi_wdata),
        .lo_wdata    (lo_wdata),
        .zero_flag   (zero_flag),
        .done        (done),
        .illegal     (illegal),
        .div0        (div0)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] op,
        input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'b0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] op,
        input logic [3:0] ra, input logic [3:0] rb, input logic [18:0] imm);
        return {op, ra, rb, imm};
    endfunction

    function automatic exp_t mk(input int lat, input logic we,
        input logic [3:0] waddr, input logic [31:0] wdata, input logic hwe,
        input logic [31:0] hi, input logic [31:0] lo, input logic zf,
        input logic ill, input logic dz, input logic [3:0] ctrl,
        input logic [31:0] b);
        exp_t e;
        e.lat = lat; e.we = we; e.waddr = waddr; e.wdata = wdata;
        e.hwe = hwe; e.hi = hi; e.lo = lo; e.zf = zf;
        e.ill = ill; e.dz = dz; e.ctrl = ctrl; e.b = b;
        return e;
    endfunction

    task automatic run_op(input logic [31:0] ins, input exp_t e,
                          input bit hold);
        int   n;
        exp_t g;
        exp_q.push_back(e);
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        chk("ready_idle", {63'b0, instr_ready}, 64'd1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        if (hold) instr = {5'b11111, 27'h0};
        else instr_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) break;
            chk("busy_ready", {63'b0, instr_ready}, 64'd0);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        g = exp_q.pop_front();
        if (!done) begin
            chk("done_timeout", {63'b0, done}, 64'd1);
            return;
        end
        chk("latency",   n,                     g.lat);
        chk("rf_we",     {63'b0, rf_we},        {63'b0, g.we});
        chk("hilo_we",   {63'b0, hilo_we},      {63'b0, g.hwe});
        chk("illegal",   {63'b0, illegal},      {63'b0, g.ill});
        chk("div0",      {63'b0, div0},         {63'b0, g.dz});
        chk("zero_flag", {63'b0, zero_flag},    {63'b0, g.zf});
        chk("alu_ctrl",  {60'b0, alu_ctrl},     {60'b0, g.ctrl});
        chk("alu_b",     {32'b0, alu_b},        {32'b0, g.b});
        if (g.we) begin
            chk("rf_waddr", {60'b0, rf_waddr}, {60'b0, g.waddr});
            chk("rf_wdata", {32'b0, rf_wdata}, {32'b0, g.wdata});
        end
        if (g.hwe) begin
            chk("hi_wdata", {32'b0, hi_wdata}, {32'b0, g.hi});
            chk("lo_wdata", {32'b0, lo_wdata}, {32'b0, g.lo});
        end
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", {63'b0, done},        64'd0);
        chk("ready_back", {63'b0, instr_ready}, 64'd1);
    endtask

    initial begin
        bit seen_done;
        for (int i = 0; i < 16; i++) regs[i] = 32'h0;
        nRst        = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {63'b0, instr_ready}, 64'd1);
        chk("rst_flags", {58'b0, done, rf_we, hilo_we, illegal, div0,
                          zero_flag}, 64'd0);
        chk("rst_alu",   {alu_a, alu_b} | {60'b0, alu_ctrl}, 64'd0);
        nRst = 1'b1;

        // add R3,R1,R2
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        run_op(r_ins(OP_ADD, 4'd3, 4'd1, 4'd2),
               mk(3, 1, 3, 32'd12, 0, 0, 0, 0, 0, 0, ALU_ADD, 32'd7), 0);

        // sub R4,R1,R1 with valid held high while busy
        regs[1] = 32'd9;
        run_op(r_ins(OP_SUB, 4'd4, 4'd1, 4'd1),
               mk(3, 1, 4, 32'd0, 0, 0, 0, 1, 0, 0, ALU_SUB, 32'd9), 1);

        // div R1,R2 with R2==0: zero_flag must stay 1
        regs[2] = 32'd0;
        run_op(r_ins(OP_DIV, 4'd1, 4'd2, 4'd0),
               mk(6, 0, 0, 0, 0, 0, 0, 1, 0, 1, ALU_DIV, 32'd0), 0);

        // illegal opcode: ALU inputs keep the div values
        run_op({5'b11111, 27'h0},
               mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, ALU_DIV, 32'd0), 0);

        // addi R5,R1,-1
        regs[1] = 32'd10;
        run_op(i_ins(OP_ADDI, 4'd5, 4'd1, 19'h7FFFF),
               mk(3, 1, 5, 32'd9, 0, 0, 0, 0, 0, 0, ALU_ADD,
                  32'hFFFF_FFFF), 0);

        // mul R1,R2: 3 * 0x80000000 = 0x1_8000_0000
        regs[1] = 32'd3;
        regs[2] = 32'h8000_0000;
        run_op(r_ins(OP_MUL, 4'd1, 4'd2, 4'd0),
               mk(6, 0, 0, 0, 1, 32'd1, 32'h8000_0000, 0, 0, 0, ALU_MUL,
                  32'h8000_0000), 0);

        // reset during EXEC of a mul
        @(negedge clk);
        instr       = r_ins(OP_MUL, 4'd1, 4'd2, 4'd0);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nRst = 1'b0;
        #1;
        chk("mid_rst_ready", {63'b0, instr_ready}, 64'd1);
        chk("mid_rst_flags", {58'b0, done, rf_we, hilo_we, illegal, div0,
                              zero_flag}, 64'd0);
        chk("mid_rst_alu", {alu_a, alu_b} | {60'b0, alu_ctrl}, 64'd0);
        chk("mid_rst_data", {hi_wdata, lo_wdata} | {32'b0, rf_wdata}
                            | {56'b0, rf_waddr, rf_raddr_a}, 64'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("mid_rst_no_done", {63'b0, seen_done}, 64'd0);
        nRst = 1'b1;

        // add R6,R1,R2 after release
        run_op(r_ins(OP_ADD, 4'd6, 4'd1, 4'd2),
               mk(3, 1, 6, 32'h8000_0003, 0, 0, 0, 0, 0, 0, ALU_ADD,
                  32'h8000_0000), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
